// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side sequencer for the UART.
//
// Accepts a byte on tx_start while idle. The byte goes to an external even-parity
// generator, and the controller waits PAR_WAIT cycles for the parity result. It then
// serializes the frame on tx: start bit, LENGTH data bits sent LSB first, an optional
// parity bit, and a stop bit. Each bit lasts CLKS_PER_BIT clocks.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   tx_start  in   request strobe, sampled only while idle
//   tx_data   in   byte to send, captured on the accepting edge
//   par_bit   in   parity result from the parity generator
//   par_en    out  enable to the parity generator
//   par_data  out  captured byte presented to the parity generator
//   tx        out  registered serial line, idles high
//   busy      out  high from the accept edge until the frame ends
//   done      out  one-cycle pulse at the frame end
module uart_tx_ctrl #(
  parameter int unsigned LENGTH       = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PAR_WAIT     = 2,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [LENGTH-1:0] tx_data,
  input  logic              par_bit,
  output logic              par_en,
  output logic [LENGTH-1:0] par_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned WaitW = (PAR_WAIT > 1) ? $clog2(PAR_WAIT) : 1;

  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitMax  = BitW'(LENGTH - 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(PAR_WAIT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StParity = 3'd1;
  localparam logic [2:0] StStart  = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
  localparam logic [2:0] StPar    = 3'd4;
  localparam logic [2:0] StStop   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [LENGTH-1:0] shift_q, shift_d;
  logic [LENGTH-1:0] par_data_q, par_data_d;
  logic              par_q, par_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              par_en_q, par_en_d;

  logic              bit_end;
  logic [LENGTH-1:0] shifted;

  assign bit_end = (baud_q == BaudMax);
  assign shifted = shift_q >> 1;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_data_d = par_data_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    baud_d     = baud_q;
    wait_d     = wait_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    par_en_d   = par_en_q;

    // The baud counter free-runs in every bit-serializing state and wraps at each bit boundary.
    if (state_q == StStart || state_q == StData || state_q == StPar || state_q == StStop) begin
      baud_d = bit_end ? '0 : baud_q + BaudW'(1);
    end

    case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d    = tx_data;
          par_data_d = tx_data;
          busy_d     = 1'b1;
          if (PARITY_EN) begin
            state_d  = StParity;
            par_en_d = 1'b1;
            wait_d   = '0;
          end else begin
            state_d = StStart;
            tx_d    = 1'b0;
            baud_d  = '0;
          end
        end
      end
      StParity: begin
        if (wait_q == WaitMax) begin
          par_d    = par_bit;
          par_en_d = 1'b0;
          state_d  = StStart;
          tx_d     = 1'b0;
          baud_d   = '0;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shifted;
          if (bit_cnt_q == BitMax) begin
            if (PARITY_EN) begin
              state_d = StPar;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            tx_d      = shifted[0];
          end
        end
      end
      StPar: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        par_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      par_data_q <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      baud_q     <= '0;
      wait_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      par_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_data_q <= par_data_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_q     <= baud_d;
      wait_q     <= wait_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      par_en_q   <= par_en_d;
    end
  end

  assign par_en   = par_en_q;
  assign par_data = par_data_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. It runs two instances side by side: one with parity and one
// without. The expected per-cycle {tx, busy, done, par_en} values are queued when a byte
// is sent, then popped and compared one cycle at a time.
module tb_uart_tx_ctrl;

  localparam int unsigned Cpb = 4;
  localparam int unsigned Pw  = 2;

  logic       clk;
  logic       rst;
  logic       tx_start_a, tx_start_b;
  logic [7:0] tx_data;
  logic       par_bit_a, par_bit_b;
  logic       par_en_a, par_en_b;
  logic [7:0] par_data_a, par_data_b;
  logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  uart_tx_ctrl #(
    .LENGTH(8), .CLKS_PER_BIT(Cpb), .PAR_WAIT(Pw), .PARITY_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start_a), .tx_data(tx_data), .par_bit(par_bit_a),
    .par_en(par_en_a), .par_data(par_data_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_ctrl #(
    .LENGTH(8), .CLKS_PER_BIT(Cpb), .PAR_WAIT(Pw), .PARITY_EN(1'b0)
  ) dut_np (
    .clk(clk), .rst(rst), .tx_start(tx_start_b), .tx_data(tx_data), .par_bit(par_bit_b),
    .par_en(par_en_b), .par_data(par_data_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parity generator model: the result is only valid after PAR_WAIT-1 enabled cycles,
  // and it is inverted before that, so an early sample gets the wrong bit.
  logic [1:0] par_cnt;
  always_ff @(posedge clk) begin
    if (!par_en_a) par_cnt <= '0;
    else if (par_cnt != 2'd3) par_cnt <= par_cnt + 2'd1;
  end
  assign par_bit_a = (par_en_a && par_cnt >= 2'(Pw - 1)) ? ^par_data_a : ~(^par_data_a);
  assign par_bit_b = 1'b1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue expected {tx, busy, done, par_en} for every cycle after the accepting edge.
  task automatic push_frame(input logic [7:0] d, input bit pe, input bit idle);
    int lead = pe ? Pw : 0;
    int nb   = pe ? 11 : 10;
    int last = lead + nb * Cpb;
    logic par = ^d;
    for (int k = 0; k <= last; k++) begin
      if (k == last) begin
        exp_q.push_back(4'b1010);
      end else if (k < lead) begin
        exp_q.push_back(4'b1101);
      end else begin
        int idx = (k - lead) / Cpb;
        logic b;
        if (idx == 0) b = 1'b0;
        else if (idx <= 8) b = d[idx-1];
        else if (pe && idx == 9) b = par;
        else b = 1'b1;
        exp_q.push_back({b, 3'b100});
      end
    end
    if (idle) exp_q.push_back(4'b1000);
  endtask

  task automatic check_one(input bit sel, input string tag);
    logic [3:0] obs, expv;
    tick();
    obs = sel ? {tx_b, busy_b, done_b, par_en_b} : {tx_a, busy_a, done_a, par_en_a};
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed {tx,busy,done,par_en}=%b", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        n_fail++;
        $error("FAIL %s: {tx,busy,done,par_en} observed %b expected %b", tag, obs, expv);
      end
    end
  endtask

  task automatic run_n(input bit sel, input int n, input string tag);
    for (int i = 0; i < n; i++) check_one(sel, tag);
  endtask

  task automatic run_all(input bit sel, input string tag);
    int n = exp_q.size();
    for (int i = 0; i < n; i++) check_one(sel, tag);
  endtask

  task automatic check_byte(input logic [7:0] obs, input logic [7:0] expv, input string tag);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Accept one byte, then drive the post-capture data value.
  task automatic send(input bit sel, input logic [7:0] d, input logic [7:0] after,
                      input string tag);
    tx_data = d;
    if (sel) tx_start_b = 1'b1;
    else tx_start_a = 1'b1;
    push_frame(d, !sel, 1'b1);
    check_one(sel, tag);
    tx_start_a = 1'b0;
    tx_start_b = 1'b0;
    tx_data    = after;
    run_all(sel, tag);
  endtask

  initial begin
    rst        = 1'b1;
    tx_start_a = 1'b0;
    tx_start_b = 1'b0;
    tx_data    = 8'h00;
    tick();
    tick();
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1000);
    rst = 1'b0;
    run_n(1'b0, 1, "reset_a");
    run_n(1'b1, 1, "reset_b");
    check_byte(par_data_a, 8'h00, "reset_par_data_a");
    check_byte(par_data_b, 8'h00, "reset_par_data_b");

    send(1'b0, 8'hA5, 8'hA5, "frame_a5");
    check_byte(par_data_a, 8'hA5, "par_data_a5");

    send(1'b0, 8'h07, 8'h07, "frame_07");

    send(1'b1, 8'hFF, 8'hFF, "frame_ff_noparity");
    check_byte(par_data_b, 8'hFF, "par_data_ff");

    // Hold tx_start through a whole frame: only one byte goes out, then the next starts
    // on the edge after done.
    tx_data    = 8'h3C;
    tx_start_a = 1'b1;
    push_frame(8'h3C, 1'b1, 1'b0);
    push_frame(8'h3C, 1'b1, 1'b1);
    run_n(1'b0, 47 + 5, "hold_start_3c");
    tx_start_a = 1'b0;
    run_all(1'b0, "back_to_back_3c");

    // Reset in the middle of the DATA bits.
    tx_data    = 8'h55;
    tx_start_a = 1'b1;
    push_frame(8'h55, 1'b1, 1'b1);
    run_n(1'b0, 1, "pre_reset_55");
    tx_start_a = 1'b0;
    run_n(1'b0, 1 + 4 + 12, "pre_reset_55");
    exp_q.delete();
    rst = 1'b1;
    exp_q.push_back(4'b1000);
    run_n(1'b0, 1, "mid_frame_reset");
    rst = 1'b0;
    check_byte(par_data_a, 8'h00, "reset_par_data_mid");
    for (int i = 0; i < 50; i++) exp_q.push_back(4'b1000);
    run_all(1'b0, "no_done_after_reset");
    send(1'b0, 8'h55, 8'h55, "frame_55_after_reset");

    // Data changes right after capture must not leak into the frame.
    send(1'b0, 8'hC3, 8'h00, "frame_c3");
    check_byte(par_data_a, 8'hC3, "par_data_c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
